fft_mag_capture: RTL and testbench

AXI4-Stream slave that sits downstream of the FFT IP and receives the complex spectrum of each windowed sample frame. It computes the squared magnitude of every bin through a two-stage pipeline and stores one full frame in an on-chip buffer. It then freezes the frame for readout by the display/host side. Frames are delimited by `tlast`; malformed frames are detected, reported and discarded.

---
 rtl/fft_mag_capture.sv | 203 ++++++++++++++++++++
 tb/tb_fft_mag_capture.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_mag_capture.sv
// fft_mag_capture: AXI4-Stream capture of one FFT frame as squared magnitudes.
// Two-stage pipeline (products, then sum) writes a FFT_LEN x 2*DW RAM. A complete
// frame is frozen until frame_ack; short/long frames pulse frame_err and are dropped.
// Optional peak search over bins 1..FFT_LEN/2-1 is built when FFT_PEAK_SEARCH_EN is
// defined; otherwise peak_bin/peak_mag are tied to zero.
module fft_mag_capture #(
  parameter int unsigned FFT_LEN = 2048,
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned DW      = 16
) (
  input  logic              i_aclk,
  input  logic              i_aresetn,
  input  logic [2*DW-1:0]   s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [2*DW-1:0]   rd_data,
  output logic              frame_done,
  output logic              frame_err,
  input  logic              frame_ack,
  output logic [ADDR_W-1:0] peak_bin,
  output logic [2*DW-1:0]   peak_mag
);

  typedef enum logic [1:0] {StCapture, StFlush, StHold, StResync} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              flush_q, flush_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              beat_acc, beat_wr, last_bin, kill, peak_clr;

  logic signed [2*DW-1:0] re_ext, im_ext;
  logic [2*DW-1:0]        re_sq_d, im_sq_d;
  logic [2*DW-1:0]        re_sq_q, im_sq_q, mag_q;
  logic [ADDR_W-1:0]      s1_addr_q, s2_addr_q;
  logic                   s1_vld_q, s2_vld_q;
  logic [2*DW-1:0]        mem_q [FFT_LEN];
  logic [2*DW-1:0]        rd_data_q;

  assign beat_acc = s_axis_tvalid & s_axis_tready;
  // FFT_LEN is a power of two, so all-ones marks the last bin.
  assign last_bin = &cnt_q;

  // Framing FSM: next state, bin counter, stage-1 write tag and status pulses.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    flush_d       = flush_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    beat_wr       = 1'b0;
    kill          = 1'b0;
    peak_clr      = 1'b0;
    s_axis_tready = 1'b0;
    unique case (state_q)
      StCapture: begin
        s_axis_tready = 1'b1;
        if (beat_acc) begin
          if (last_bin && s_axis_tlast) begin
            beat_wr = 1'b1;
            cnt_d   = '0;
            flush_d = 1'b0;
            state_d = StFlush;
          end else if (last_bin || s_axis_tlast) begin
            // Malformed frame: drop the offending beat and anything still in flight.
            err_d    = 1'b1;
            cnt_d    = '0;
            kill     = 1'b1;
            peak_clr = 1'b1;
            if (!s_axis_tlast) state_d = StResync;
          end else begin
            beat_wr = 1'b1;
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      StFlush: begin
        if (flush_q) begin
          done_d  = 1'b1;
          state_d = StHold;
        end else begin
          flush_d = 1'b1;
        end
      end
      StHold: begin
        if (frame_ack) begin
          cnt_d    = '0;
          peak_clr = 1'b1;
          state_d  = StCapture;
        end
      end
      StResync: begin
        s_axis_tready = 1'b1;
        if (beat_acc && s_axis_tlast) begin
          peak_clr = 1'b1;
          state_d  = StCapture;
        end
      end
      default: state_d = StCapture;
    endcase
  end

  // FSM state and status pulse registers.
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state_q <= StCapture;
      cnt_q   <= '0;
      flush_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign re_ext  = {{DW{s_axis_tdata[DW-1]}}, s_axis_tdata[DW-1:0]};
  assign im_ext  = {{DW{s_axis_tdata[2*DW-1]}}, s_axis_tdata[2*DW-1:DW]};
  assign re_sq_d = re_ext * re_ext;
  assign im_sq_d = im_ext * im_ext;

  // Magnitude pipeline: stage 1 squares, stage 2 sums; valid tags mark real beats.
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      re_sq_q   <= '0;
      im_sq_q   <= '0;
      mag_q     <= '0;
      s1_addr_q <= '0;
      s2_addr_q <= '0;
    end else begin
      s1_vld_q <= beat_wr;
      s2_vld_q <= s1_vld_q & ~kill;
      if (beat_wr) begin
        re_sq_q   <= re_sq_d;
        im_sq_q   <= im_sq_d;
        s1_addr_q <= cnt_q;
      end
      if (s1_vld_q) begin
        mag_q     <= re_sq_q + im_sq_q;
        s2_addr_q <= s1_addr_q;
      end
    end
  end

  // Frame buffer write port (contents survive reset).
  always_ff @(posedge i_aclk) begin
    if (s2_vld_q) mem_q[s2_addr_q] <= mag_q;
  end

  // Registered read port; holds its value while rd_en is low.
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data    = rd_data_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;

`ifdef FFT_PEAK_SEARCH_EN
  logic [ADDR_W-1:0] peak_bin_q;
  logic [2*DW-1:0]   peak_mag_q;
  logic              peak_cand;

  // Positive-frequency bins only: nonzero and below FFT_LEN/2.
  assign peak_cand = s2_vld_q & ~s2_addr_q[ADDR_W-1] & (|s2_addr_q);

  // Running maximum; strict compare keeps the lowest bin on ties.
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      peak_bin_q <= '0;
      peak_mag_q <= '0;
    end else if (peak_clr) begin
      peak_bin_q <= '0;
      peak_mag_q <= '0;
    end else if (peak_cand && (mag_q > peak_mag_q)) begin
      peak_bin_q <= s2_addr_q;
      peak_mag_q <= mag_q;
    end
  end

  assign peak_bin = peak_bin_q;
  assign peak_mag = peak_mag_q;
`else
  logic unused_peak_clr;
  assign unused_peak_clr = peak_clr;
  assign peak_bin        = '0;
  assign peak_mag        = '0;
`endif

endmodule

// File: tb/tb_fft_mag_capture.sv
// Scoreboard bench for fft_mag_capture: reads and status events push expectations,
// a negedge monitor pops and compares whenever the DUT presents a result.
module tb_fft_mag_capture;
  localparam int FFT_LEN = 2048;
  localparam int ADDR_W  = 11;
  localparam int DW      = 16;
  localparam byte EvDone = 8'd68;
  localparam byte EvErr  = 8'd69;

  logic              clk = 1'b0;
  logic              rstn;
  logic [2*DW-1:0]   tdata;
  logic              tvalid, tlast, tready;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [2*DW-1:0]   rd_data;
  logic              frame_done, frame_err, frame_ack;
  logic [ADDR_W-1:0] peak_bin;
  logic [2*DW-1:0]   peak_mag;

  int     checks = 0;
  int     errors = 0;
  longint rd_q[$];
  byte    evt_q[$];
  logic   rd_seen = 1'b0;

  always #5 clk = ~clk;

  fft_mag_capture #(.FFT_LEN(FFT_LEN), .ADDR_W(ADDR_W), .DW(DW)) dut (
    .i_aclk       (clk),
    .i_aresetn    (rstn),
    .s_axis_tdata (tdata),
    .s_axis_tvalid(tvalid),
    .s_axis_tlast (tlast),
    .s_axis_tready(tready),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .frame_done   (frame_done),
    .frame_err    (frame_err),
    .frame_ack    (frame_ack),
    .peak_bin     (peak_bin),
    .peak_mag     (peak_mag)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Stimulus patterns: 0 ramp re=k; 1 single tone at bin 100; 2 full-scale at bins 5 and 9.
  function automatic int bin_re(input int kind, input int k);
    if (kind == 0) return k;
    if (kind == 1) return (k == 100) ? 3000 : 0;
    return (k == 5 || k == 9) ? -32768 : 0;
  endfunction

  function automatic int bin_im(input int kind, input int k);
    if (kind == 1) return (k == 100) ? -4000 : 0;
    if (kind == 2) return (k == 5 || k == 9) ? -32768 : 0;
    return 0;
  endfunction

  function automatic longint exp_mag(input int kind, input int k);
    longint re = bin_re(kind, k);
    longint im = bin_im(kind, k);
    return re * re + im * im;
  endfunction

  always @(posedge clk) rd_seen <= rd_en;

  // Monitor: pops an expectation for every read result and status pulse.
  always @(negedge clk) begin
    if (rd_seen) begin
      if (rd_q.size() == 0) chk("rd_unexpected", rd_q.size(), 1);
      else chk("rd_data", rd_data, rd_q.pop_front());
    end
    if (frame_done === 1'b1) begin
      if (evt_q.size() == 0) chk("frame_done_spurious", frame_done, 0);
      else chk("frame_done_evt", EvDone, evt_q.pop_front());
    end
    if (frame_err === 1'b1) begin
      if (evt_q.size() == 0) chk("frame_err_spurious", frame_err, 0);
      else chk("frame_err_evt", EvErr, evt_q.pop_front());
    end
  end

  // All tasks start and end 1ns after a rising edge.
  task automatic beat(input int re, input int im, input bit last, input bit gaps);
    if (gaps) begin
      while ($urandom_range(1, 0) == 1) begin
        @(posedge clk);
        #1;
      end
    end
    tdata  = {im[DW-1:0], re[DW-1:0]};
    tvalid = 1'b1;
    tlast  = last;
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic send(input int kind, input int nbeats, input int last_at, input bit gaps);
    for (int k = 0; k < nbeats; k++) beat(bin_re(kind, k), bin_im(kind, k), k == last_at, gaps);
  endtask

  task automatic good_frame(input int kind, input bit gaps);
    evt_q.push_back(EvDone);
    send(kind, FFT_LEN, FFT_LEN - 1, gaps);
    @(negedge clk);
    chk("tready_flush", tready, 0);
    chk("done_t1", frame_done, 0);
    @(negedge clk);
    chk("done_t2", frame_done, 0);
    @(negedge clk);
    chk("done_t3", frame_done, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int addr, input longint exp);
    rd_q.push_back(exp);
    rd_en   = 1'b1;
    rd_addr = addr[ADDR_W-1:0];
    @(posedge clk);
    #1;
    rd_en = 1'b0;
  endtask

  task automatic chk_peak(input int bin, input longint mag);
`ifdef FFT_PEAK_SEARCH_EN
    chk("peak_bin", peak_bin, bin);
    chk("peak_mag", peak_mag, mag);
`else
    chk("peak_bin_tied", peak_bin, 0);
    chk("peak_mag_tied", peak_mag, 0);
    if (bin < 0) $display("unreachable %0d", mag);
`endif
  endtask

  task automatic ack();
    chk("tready_hold", tready, 0);
    frame_ack = 1'b1;
    @(posedge clk);
    #1;
    frame_ack = 1'b0;
    @(negedge clk);
    chk("tready_after_ack", tready, 1);
    chk("peak_mag_cleared", peak_mag, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_tready", tready, 1);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_peak_bin", peak_bin, 0);
    chk("rst_peak_mag", peak_mag, 0);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; tdata = '0; tvalid = 1'b0; tlast = 1'b0;
    rd_en = 1'b0; rd_addr = '0; frame_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Ramp frame, gap-free.
    good_frame(0, 1'b0);
    rd(0, 0); rd(1, 1); rd(100, 10000); rd(2047, 4190209);
    repeat (3) @(posedge clk);
    #1;
    chk("rd_hold", rd_data, 4190209);
    chk_peak(1023, 1046529);
    ack();

    // Single tone at bin 100.
    good_frame(1, 1'b0);
    rd(100, 25000000); rd(0, 0); rd(101, 0);
    chk_peak(100, 25000000);
    ack();

    // Full-scale negative components at bins 5 and 9; tie keeps bin 5.
    good_frame(2, 1'b0);
    rd(5, exp_mag(2, 5)); rd(9, 64'd2147483648); rd(6, 0);
    chk_peak(5, 64'd2147483648);
    ack();

    // Short frame (tlast on beat 10), then a good ramp frame.
    evt_q.push_back(EvErr);
    send(0, 11, 10, 1'b0);
    @(negedge clk);
    chk("short_err_pulse", frame_err, 1);
    chk("short_tready", tready, 1);
    @(posedge clk);
    #1;
    good_frame(0, 1'b0);
    rd(0, 0); rd(1, 1); rd(10, 100); rd(2047, 4190209);
    ack();

    // Long frame, 5 dropped beats, then the tone frame.
    evt_q.push_back(EvErr);
    send(0, FFT_LEN, -1, 1'b0);
    @(negedge clk);
    chk("long_err_pulse", frame_err, 1);
    @(posedge clk);
    #1;
    send(0, 5, 4, 1'b0);
    good_frame(1, 1'b0);
    rd(1, 0); rd(100, 25000000); rd(4, 0);
    chk_peak(100, 25000000);
    ack();

    // Ramp frame with random tvalid gaps must match the gap-free result.
    good_frame(0, 1'b1);
    rd(0, 0); rd(1, 1); rd(100, 10000); rd(2047, 4190209);
    chk_peak(1023, 1046529);
    ack();

    // Reset in the middle of a frame, then a complete ramp frame.
    send(1, 700, -1, 1'b1);
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    chk_reset_vals();
    @(posedge clk);
    #1;
    good_frame(0, 1'b0);
    rd(100, 10000); rd(2047, 4190209); rd(700, 490000);
    chk_peak(1023, 1046529);
    ack();

    repeat (3) @(posedge clk);
    #1;
    chk("rd_q_drained", rd_q.size(), 0);
    chk("evt_q_drained", evt_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
